crc_stream_encoder: RTL and testbench
=====================================

# crc_stream_encoder

Parametrised, streaming CRC encoder and the successor of the fixed 4-bit combinational CRC encoder. It accepts frames of DATA_W-bit words over a valid/ready handshake and forwards each word unchanged through a registered output stage. After the last word of a frame, it appends one extra beat carrying the frame CRC. It sits between a frame source and the serialiser/link layer.

## Interface
- DATA_W, 4: data word width; must be ≥ CRC_W.
- CRC_W, 3: CRC width.
- POLY, 3'b011: generator polynomial without the implicit x^CRC_W term; default is x^3+x+1.
- INIT, 0: CRC register value at the start of each frame.

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- in_data  in  DATA_W  input word, MSB processed first.
- in_last  in  1  marks the last word of a frame.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat when out_valid && out_ready.
- out_data  out  DATA_W  pass-through word, or {zeros, CRC} on the CRC beat.
- out_crc  out  1  high on the appended CRC beat.
- out_last  out  1  high on the CRC beat only; this is the frame end.

## Operation
- CRC: MSB-first polynomial division, no reflection, no final XOR.
  - Each accepted word updates crc <= next(crc, in_data) in one cycle.
  - The update is an unrolled DATA_W-step shift/XOR on a CRC_W-bit register.
- FSM has two states:
  - DATA: in_ready = !out_valid || out_ready. An accepted word loads the output register with out_crc=0 and out_last=0, and updates crc. If in_last is set on that word, move to CRC.
  - CRC: in_ready=0. When the output register frees (!out_valid || out_ready), load out_data = {zeros, next crc}, out_crc=1, out_last=1. Reset crc to INIT and return to DATA.
- A single-word frame is legal: CRC = remainder of word·x^CRC_W.
- Backpressure: the output register holds its value while out_valid && !out_ready. No word is dropped or duplicated.
- Illegal configuration, which fails elaboration:
  - CRC_W > DATA_W
  - CRC_W < 1

## Timing
- Reset values:
  - in_ready=0 during the reset cycle, then 1.
  - out_valid=0, out_data=0, out_crc=0, out_last=0.
  - crc=INIT, state=DATA.
- Latency: an accepted word appears on out_data the next cycle.
- The CRC beat is loaded in the cycle after the in_last word is accepted, provided the output is free. Otherwise it is loaded in the first cycle the output frees.
- Throughput: a frame of N words occupies N+1 output beats. The bubble on the input side is the single CRC cycle.
- in_ready is combinational from out_valid, out_ready and state. in_valid must not depend on in_ready.
- Reset mid-frame discards the partial frame and any pending beat. The next accepted word starts a new frame from INIT.
- When out_ready and an accepted input happen in the same cycle, the output register reloads with no bubble.

## Configuration
- CRC_ENC_STATS_EN:
  - Defined: adds output frame_count (16-bit). It increments on each accepted CRC beat (out_valid && out_ready && out_crc) and wraps 0xFFFF→0. Reset value is 0.
  - Undefined: no port and no counter logic.

## Structure
- Shared package crc_pkg holds:
  - the state enum (ST_DATA, ST_CRC)
  - a crc_next function parameterised on width/poly
  - default constants for the 4/3 x^3+x+1 configuration.
- One sub-module, crc_step_unit: the combinational DATA_W-bit CRC update. This keeps the FSM/handshake shell separate and lets the unit be reused by the future checker.

## Test plan
- Single-word frames with defaults, out_ready=1:
  - 1010 → data beat 1010, then CRC beat 0011 with out_last=1.
  - 1101 → CRC 001.
  - 1111 → CRC 111.
  - 0100 → CRC 111.
- Two-word frames:
  - {1010,1101} → CRC 000.
  - {1101,1010} → CRC 101.
  - Back-to-back frames show exactly one input stall cycle per frame.
- Random out_ready backpressure over 1000 frames: output stream equals input words plus software-model CRCs, with none dropped or duplicated.
- Reset asserted on the cycle after the first word of a two-word frame: all outputs are at reset values next cycle. The following frame {1010} still yields CRC 011.
- Non-default config DATA_W=8, CRC_W=8, POLY=8'h07: frame {0x31…0x39} ("123456789") → CRC 0xF4.
- With CRC_ENC_STATS_EN: after 3 frames frame_count=3. After forcing 65536 frames it wraps to 0.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared definitions for the streaming CRC encoder and its future checker.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents: FSM state enum, default 4/3 configuration (x^3+x+1), and a
// width/poly-generic crc_next() helper for reuse outside the encoder.
package crc_pkg;

    typedef enum logic [0:0] {
        ST_DATA = 1'b0,
        ST_CRC  = 1'b1
    } crc_state_e;

    // Default configuration: 4-bit words, 3-bit CRC, x^3 + x + 1.
    localparam int         DEF_DATA_W = 4;
    localparam int         DEF_CRC_W  = 3;
    localparam logic [2:0] DEF_POLY   = 3'b011;
    localparam logic [2:0] DEF_INIT   = 3'b000;

    // Widest CRC/word the generic helper handles.
    localparam int CRC_MAX_W = 32;

    // MSB-first CRC update of one data_w-bit word, no reflection, no final
    // XOR. Operands are zero-extended to CRC_MAX_W; the result is masked to
    // crc_w bits.
    function automatic logic [CRC_MAX_W-1:0] crc_next(
        input logic [CRC_MAX_W-1:0] crc,
        input logic [CRC_MAX_W-1:0] data,
        input logic [CRC_MAX_W-1:0] poly,
        input int                   crc_w,
        input int                   data_w
    );
        logic [CRC_MAX_W-1:0] c;
        logic [CRC_MAX_W-1:0] mask;
        logic                 fb;
        c    = crc;
        mask = '0;
        fb   = 1'b0;
        for (int j = 0; j < CRC_MAX_W; j++) begin
            mask[j] = (j < crc_w);
        end
        for (int i = CRC_MAX_W - 1; i >= 0; i--) begin
            if (i < data_w) begin
                fb = c[crc_w-1] ^ data[i];
                c  = c << 1;
                if (fb) begin
                    c = c ^ poly;
                end
            end
        end
        return c & mask;
    endfunction

endpackage

// File: rtl/crc_step_unit.sv
// Combinational DATA_W-bit CRC update: crc_out = next(crc_in, data_in).
// Latency: 0 cycles (pure combinational, unrolled shift/XOR).
// Backpressure: none; caller decides when to register the result.
//
// Ports:
//   crc_in  [CRC_W-1:0]  current CRC register value
//   data_in [DATA_W-1:0] word to fold in, MSB first
//   crc_out [CRC_W-1:0]  updated CRC
module crc_step_unit
    import crc_pkg::*;
#(
    parameter int               DATA_W = DEF_DATA_W,
    parameter int               CRC_W  = DEF_CRC_W,
    parameter logic [CRC_W-1:0] POLY   = DEF_POLY
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [CRC_W-1:0]  crc_out
);

    logic [CRC_W-1:0] acc;
    logic             fb;

    // One shift/XOR step per data bit, MSB of the word entering first.
    always_comb begin
        acc = crc_in;
        fb  = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb  = acc[CRC_W-1] ^ data_in[i];
            acc = acc << 1;
            if (fb) begin
                acc = acc ^ POLY;
            end
        end
        crc_out = acc;
    end

endmodule

// File: rtl/crc_stream_encoder.sv
// Streaming CRC encoder: forwards frame words and appends one CRC beat.
// Latency: 1 cycle input-to-output; CRC beat follows the last word.
// Backpressure: valid/ready; output register holds while !out_ready, input
//   stalls for one cycle per frame while the CRC beat is loaded.
//
// Optional feature macro: CRC_ENC_STATS_EN adds a 16-bit frame_count output
// counting accepted CRC beats (wraps at 0xFFFF).
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last  input word stream
//   out_valid/out_ready/out_data       output beat stream
//   out_crc, out_last                  flags on the appended CRC beat
//   frame_count                        (CRC_ENC_STATS_EN only) frame counter
module crc_stream_encoder
    import crc_pkg::*;
#(
    parameter int               DATA_W = DEF_DATA_W,
    parameter int               CRC_W  = DEF_CRC_W,
    parameter logic [CRC_W-1:0] POLY   = DEF_POLY,
    parameter logic [CRC_W-1:0] INIT   = DEF_INIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_crc,
    output logic              out_last
`ifdef CRC_ENC_STATS_EN
    ,
    output logic [15:0]       frame_count
`endif
);

    // Reject configurations where the CRC cannot fit in a data beat.
    generate
        if (CRC_W < 1) begin : g_bad_crc_w_small
            $error("crc_stream_encoder: CRC_W must be at least 1");
        end
        if (CRC_W > DATA_W) begin : g_bad_crc_w_large
            $error("crc_stream_encoder: CRC_W must not exceed DATA_W");
        end
    endgenerate

    crc_state_e        state_q, state_d;
    logic [CRC_W-1:0]  crc_q, crc_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_crc_q, out_crc_d;
    logic              out_last_q, out_last_d;
    logic [CRC_W-1:0]  crc_step;
    logic              out_free;
    logic              in_fire;

    crc_step_unit #(
        .DATA_W (DATA_W),
        .CRC_W  (CRC_W),
        .POLY   (POLY)
    ) u_step (
        .crc_in  (crc_q),
        .data_in (in_data),
        .crc_out (crc_step)
    );

    // Output register can take a new beat when empty or being drained now.
    assign out_free = !out_valid_q || out_ready;
    assign in_ready = !reset && (state_q == ST_DATA) && out_free;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_crc_d   = out_crc_q;
        out_last_d  = out_last_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_DATA: begin
                if (in_fire) begin
                    out_valid_d = 1'b1;
                    out_data_d  = in_data;
                    out_crc_d   = 1'b0;
                    out_last_d  = 1'b0;
                    crc_d       = crc_step;
                    if (in_last) begin
                        state_d = ST_CRC;
                    end
                end
            end
            ST_CRC: begin
                // crc_q already includes the last word of the frame.
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = DATA_W'(crc_q);
                    out_crc_d   = 1'b1;
                    out_last_d  = 1'b1;
                    crc_d       = INIT;
                    state_d     = ST_DATA;
                end
            end
            default: begin
                state_d = ST_DATA;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_DATA;
            crc_q       <= INIT;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_crc_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_crc_q   <= out_crc_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_crc   = out_crc_q;
    assign out_last  = out_last_q;

`ifdef CRC_ENC_STATS_EN
    logic [15:0] frame_count_q, frame_count_d;

    always_comb begin
        frame_count_d = frame_count_q;
        if (out_valid_q && out_ready && out_crc_q) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_q <= 16'd0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_crc_stream_encoder.sv
// Scoreboard bench for crc_stream_encoder: stimulus pushes expected beats,
// a monitor drives out_ready and pops/compares every accepted output beat.
// Also runs an 8-bit CRC-8 (poly 0x07) instance on "123456789".
module tb_crc_stream_encoder;

    typedef struct {
        logic [3:0] data;
        logic       crc;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, in_last;
    logic [3:0] in_data;
    logic       out_valid, out_ready, out_crc, out_last;
    logic [3:0] out_data;

    logic       in_valid8, in_ready8, in_last8;
    logic [7:0] in_data8;
    logic       out_valid8, out_ready8, out_crc8, out_last8;
    logic [7:0] out_data8;

`ifdef CRC_ENC_STATS_EN
    logic [15:0] frame_count;
    logic [15:0] frame_count8;
`endif

    int    total = 0;
    int    bad   = 0;
    int    frames_since_reset = 0;
    bit    rand_bp = 1'b0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    crc_stream_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_crc   (out_crc),
        .out_last  (out_last)
`ifdef CRC_ENC_STATS_EN
        ,
        .frame_count (frame_count)
`endif
    );

    crc_stream_encoder #(
        .DATA_W (8),
        .CRC_W  (8),
        .POLY   (8'h07),
        .INIT   (8'h00)
    ) dut8 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_data   (in_data8),
        .in_last   (in_last8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_data  (out_data8),
        .out_crc   (out_crc8),
        .out_last  (out_last8)
`ifdef CRC_ENC_STATS_EN
        ,
        .frame_count (frame_count8)
`endif
    );

    // Reference: textbook long division of (message bits . x^3) by 1011.
    function automatic logic [2:0] model_crc(input logic [3:0] words[$]);
        bit         bits[$];
        logic [3:0] gen;
        int         n;
        gen = 4'b1011;
        foreach (words[i]) begin
            for (int b = 3; b >= 0; b--) bits.push_back(words[i][b]);
        end
        for (int z = 0; z < 3; z++) bits.push_back(1'b0);
        n = bits.size();
        for (int i = 0; i + 3 < n; i++) begin
            if (bits[i]) begin
                for (int k = 0; k < 4; k++) bits[i+k] = bits[i+k] ^ gen[3-k];
            end
        end
        return {bits[n-3], bits[n-2], bits[n-1]};
    endfunction

    task automatic push_exp(input logic [3:0] d, input logic c, input logic l);
        beat_t b;
        b.data = d;
        b.crc  = c;
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic check1(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Called at a negedge; returns at the negedge after the word is taken.
    task automatic send_word(input logic [3:0] w, input logic l, output int stalls);
        bit acc;
        stalls   = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        in_last  = l;
        for (int t = 0; t < 200 && !acc; t++) begin
            #1;
            acc = in_ready;
            @(negedge clk);
            if (!acc) stalls++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready never rose for word %0h", w);
        end
    endtask

    task automatic drain(input int budget, input string name);
        int left;
        for (int t = 0; t < budget && exp_q.size() != 0; t++) @(negedge clk);
        repeat (2) @(negedge clk);
        left = exp_q.size();
        total++;
        if (left != 0) begin
            bad++;
            $display("FAIL %s: %0d beats still pending, required 0", name, left);
            exp_q.delete();
        end
    endtask

    // Monitor: owns out_ready, checks every beat accepted by downstream.
    initial begin : monitor
        beat_t e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (!reset && out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: data=%0h crc=%0b last=%0b, none expected",
                             out_data, out_crc, out_last);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_crc !== e.crc || out_last !== e.last) begin
                        bad++;
                        $display("FAIL beat: got data=%0h crc=%0b last=%0b expected data=%0h crc=%0b last=%0b",
                                 out_data, out_crc, out_last, e.data, e.crc, e.last);
                    end
                end
            end
        end
    end

    logic [3:0] dir_words [8];
    logic       dir_last  [8];
    logic [2:0] dir_crc   [6];
    logic [7:0] msg8      [9];

    initial begin : stimulus
        int         st;
        int         stall_sum;
        int         len;
        logic [3:0] d;
        logic [3:0] words[$];
        bit         seen;

        dir_words = '{4'b1010, 4'b1101, 4'b1111, 4'b0100, 4'b1010, 4'b1101, 4'b1101, 4'b1010};
        dir_last  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        dir_crc   = '{3'b011, 3'b001, 3'b111, 3'b111, 3'b000, 3'b101};
        msg8      = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = 4'h0;
        in_last    = 1'b0;
        in_valid8  = 1'b0;
        in_data8   = 8'h00;
        in_last8   = 1'b0;
        out_ready8 = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        check1("rst_in_ready",  16'(in_ready),  16'd0);
        check1("rst_out_valid", 16'(out_valid), 16'd0);
        check1("rst_out_data",  16'(out_data),  16'd0);
        check1("rst_out_flags", {14'd0, out_crc, out_last}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        #2;
        check1("post_rst_in_ready", 16'(in_ready), 16'd1);
        @(negedge clk);

        // Directed frames back-to-back with out_ready=1; one stall per frame.
        stall_sum = 0;
        begin
            int fi;
            fi = 0;
            for (int i = 0; i < 8; i++) begin
                push_exp(dir_words[i], 1'b0, 1'b0);
                if (dir_last[i]) begin
                    push_exp({1'b0, dir_crc[fi]}, 1'b1, 1'b1);
                    fi++;
                end
                send_word(dir_words[i], dir_last[i], st);
                stall_sum += st;
            end
        end
        in_valid = 1'b0;
        frames_since_reset += 6;
        drain(50, "drain_directed");
        check1("b2b_stalls", 16'(stall_sum), 16'd5);

        // Reset on the cycle after the first word of a two-word frame.
        send_word(4'b1010, 1'b0, st);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        #2;
        check1("midrst_out_valid", 16'(out_valid), 16'd0);
        check1("midrst_out_data",  16'(out_data),  16'd0);
        check1("midrst_out_flags", {14'd0, out_crc, out_last}, 16'd0);
        check1("midrst_in_ready",  16'(in_ready),  16'd0);
        @(negedge clk);
        reset = 1'b0;
        frames_since_reset = 0;
        push_exp(4'b1010, 1'b0, 1'b0);
        push_exp(4'b0011, 1'b1, 1'b1);
        send_word(4'b1010, 1'b1, st);
        in_valid = 1'b0;
        frames_since_reset++;
        drain(50, "drain_after_reset");

        // Random frames under random backpressure.
        rand_bp = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(1, 4);
            words.delete();
            for (int w = 0; w < len; w++) begin
                d = 4'($urandom);
                words.push_back(d);
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
                push_exp(d, 1'b0, 1'b0);
                send_word(d, (w == len - 1), st);
            end
            push_exp({1'b0, model_crc(words)}, 1'b1, 1'b1);
            frames_since_reset++;
        end
        in_valid = 1'b0;
        drain(2000, "drain_random");
        rand_bp = 1'b0;

`ifdef CRC_ENC_STATS_EN
        check1("frame_count", frame_count, 16'(frames_since_reset));
`endif

        // CRC-8 poly 0x07 over "123456789" on the 8-bit instance.
        for (int i = 0; i < 9; i++) begin
            bit acc;
            acc       = 1'b0;
            in_valid8 = 1'b1;
            in_data8  = msg8[i];
            in_last8  = (i == 8);
            for (int t = 0; t < 50 && !acc; t++) begin
                #1;
                acc = in_ready8;
                @(negedge clk);
            end
            if (!acc) begin
                total++;
                bad++;
                $display("FAIL crc8_send_timeout: byte %0d not accepted", i);
            end
        end
        in_valid8 = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 30 && !seen; t++) begin
            #1;
            if (out_valid8 && out_crc8) begin
                seen = 1'b1;
                check1("crc8_check",  16'(out_data8), 16'h00F4);
                check1("crc8_last",   16'(out_last8), 16'd1);
            end
            @(negedge clk);
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL crc8_beat: no CRC beat seen, required one with 0xf4");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
